// File: rtl/binary_hexadecimal_decoder.sv
// Streaming 4-to-16 decoder: 4-bit codes are queued in a small FIFO and each
// one is emitted as a registered one-hot word over a valid/ready output.
module binary_hexadecimal_decoder #(
  parameter int DEPTH      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_onehot,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [15:0] IDLE_WORD = (ACTIVE_LOW != 0) ? 16'hFFFF : 16'h0000;

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, and a held
  // output word stays stable until it is taken.

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_onehot_q, out_onehot_d;

  logic wr_en;
  logic load_en;

  function automatic logic [15:0] decode(input logic [3:0] code);
    logic [15:0] word;
    word = 16'h0001 << code;
    return (ACTIVE_LOW != 0) ? ~word : word;
  endfunction

  // Full is judged from registered count only, so a same-edge pop never frees a slot.
  assign in_ready = !rst && (count_q < DEPTH_C);
  assign wr_en    = in_valid && in_ready;
  assign load_en  = (!out_valid_q || out_ready) && (count_q != '0);

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_onehot_d = out_onehot_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = in_code;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (load_en) begin
      out_onehot_d = decode(mem_q[rd_ptr_q]);
      out_valid_d  = 1'b1;
      rd_ptr_d     = rd_ptr_q + PW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      out_onehot_d = IDLE_WORD;
    end

    case ({wr_en, load_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_onehot_q <= IDLE_WORD;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign count      = count_q;

endmodule

// File: tb/tb_binary_hexadecimal_decoder.sv
// Directed bench for binary_hexadecimal_decoder: active-high and active-low
// instances, checked with immediate assertions against hand-computed values.
module tb_binary_hexadecimal_decoder;

  logic        clk;
  logic        rst, al_rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_code;
  logic [15:0] out_onehot;
  logic [2:0]  count;
  logic        al_in_valid, al_in_ready, al_out_valid, al_out_ready;
  logic [3:0]  al_in_code;
  logic [15:0] al_out_onehot;
  logic [2:0]  al_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  binary_hexadecimal_decoder #(.DEPTH(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .count(count)
  );

  binary_hexadecimal_decoder #(.DEPTH(4), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(al_rst), .in_valid(al_in_valid), .in_ready(al_in_ready),
    .in_code(al_in_code), .out_valid(al_out_valid), .out_ready(al_out_ready),
    .out_onehot(al_out_onehot), .count(al_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drain the main instance with out_ready high, comparing each word to exp_q.
  task automatic drain(input string tag, input int cycles);
    logic [15:0] exp;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (out_valid) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        chk(tag, out_onehot, exp);
      end
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_idle"}, out_onehot, 16'h0000);
  endtask

  initial begin
    int got, first, last;
    logic [15:0] exp;

    // 1. reset held two edges with in_valid high
    rst = 1'b1; al_rst = 1'b1;
    in_valid = 1'b1; in_code = 4'h5; out_ready = 1'b1;
    al_in_valid = 1'b0; al_in_code = 4'h0; al_out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_onehot", out_onehot, 16'h0000);
    chk("rst_count", count, 3'd0);
    chk("al_rst_idle", al_out_onehot, 16'hFFFF);
    rst = 1'b0; al_rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // 2. single code 9
    tick();
    in_valid = 1'b1; in_code = 4'h9;
    tick();
    in_valid = 1'b0;
    chk("single_count", count, 3'd1);
    chk("single_not_yet", out_valid, 1'b0);
    tick();
    chk("single_valid", out_valid, 1'b1);
    chk("single_word", out_onehot, 16'h0200);
    chk("single_count0", count, 3'd0);
    tick();
    chk("single_drop", out_valid, 1'b0);
    chk("single_idle", out_onehot, 16'h0000);

    // 3. sweep 0..15 back to back
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("sweep_word", out_onehot, exp);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 16) begin
        in_valid = 1'b1; in_code = c[3:0];
        exp_q.push_back(16'h0001 << c);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("sweep_got", got, 16);
    chk("sweep_first", first, 2);
    chk("sweep_span", last - first, 15);

    // 4. backpressure: 3,5,A,C,E with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 4'h3; tick();
    in_code = 4'h5; tick();
    in_code = 4'hA; tick();
    in_code = 4'hC; tick();
    in_code = 4'hE; tick();
    chk("bp_word", out_onehot, 16'h0008);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_count", count, 3'd4);
    chk("bp_in_ready", in_ready, 1'b0);
    tick();
    chk("bp_hold_word", out_onehot, 16'h0008);
    chk("bp_stall_count", count, 3'd4);
    exp_q.push_back(16'h0020); exp_q.push_back(16'h0400);
    exp_q.push_back(16'h1000); exp_q.push_back(16'h4000);
    tick();
    drain("bp_drain", 6);

    // 5. full FIFO: pop and in_valid on the same edge
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_code = k[3:0];
      tick();
    end
    chk("full_count", count, 3'd4);
    chk("full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1; in_code = 4'h6;
    tick();
    chk("full_pop_count", count, 3'd3);
    chk("full_pop_word", out_onehot, 16'h0004);
    out_ready = 1'b0;
    tick();
    chk("full_late_write", count, 3'd4);
    exp_q.push_back(16'h0008); exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0020); exp_q.push_back(16'h0040);
    drain("full_drain", 7);

    // 6. active-low instance
    al_in_valid = 1'b1; al_in_code = 4'h0; al_out_ready = 1'b1;
    tick();
    al_in_valid = 1'b0;
    tick();
    chk("al_valid", al_out_valid, 1'b1);
    chk("al_word", al_out_onehot, 16'hFFFE);
    tick();
    chk("al_idle", al_out_onehot, 16'hFFFF);
    chk("al_drop", al_out_valid, 1'b0);
    al_out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      al_in_valid = 1'b1; al_in_code = k[3:0];
      tick();
    end
    chk("al_buffered", al_count, 3'd3);
    al_in_valid = 1'b0; al_rst = 1'b1;
    tick();
    chk("al_flush_count", al_count, 3'd0);
    chk("al_flush_valid", al_out_valid, 1'b0);
    chk("al_flush_word", al_out_onehot, 16'hFFFF);
    chk("al_flush_ready", al_in_ready, 1'b0);
    al_rst = 1'b0; al_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("al_nothing_out", al_out_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
